dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: ADDR_W, 32, address width; DATA_W, 32, data width; CNT_W, 16, conflict counter width.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-003 The following ports SHALL be provided:
- req0  input  1  CPU port access request (level)
- we0  input  1  CPU port: 1 = write, 0 = read
- addr0  input  ADDR_W  CPU port address
- wdata0  input  DATA_W  CPU port write data
- gnt0  output  1  CPU port completion pulse
- rdata0  output  DATA_W  CPU port read data
- req1, we1, addr1, wdata1, gnt1, rdata1: same directions, widths and meanings for the DMA port
- memAddr  output  ADDR_W  data memory address
- memWriteData  output  DATA_W  data memory write data
- memRead  output  1  data memory read strobe
- memWrite  output  1  data memory write strobe
- memReadData  input  DATA_W  data memory read data (combinational)
- busy  output  1  high in any state other than IDLE
- conflictCnt  output  CNT_W  saturating count of lost arbitrations

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, RESP; all outputs SHALL be registered.
REQ-005 IDLE: at an edge with req0|req1 high, the block SHALL select a winner, latch its we/addr/wdata, load memAddr/memWriteData, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-006 ACCESS SHALL last exactly one cycle with memRead = ~we or memWrite = we of the winner; the other strobe SHALL be 0.
REQ-007 On the ACCESS->RESP edge, a read SHALL capture memReadData into the winner's rdata; a write SHALL leave both rdata outputs unchanged.
REQ-008 RESP SHALL last one cycle with only the winner's gnt high, then SHALL return to IDLE unconditionally; req SHALL NOT be sampled in RESP.
REQ-009 Latency: req sampled at edge T0 -> strobe high in cycle T0..T1 -> gnt high and rdata valid in cycle T1..T2; peak throughput SHALL be one access per 3 cycles.
REQ-010 Requesters SHALL hold req/we/addr/wdata stable until they sample gnt=1, and SHALL drop req at that edge; changes to the inputs after the IDLE edge SHALL NOT affect the access in flight.
REQ-011 Outside ACCESS, memRead and memWrite SHALL be 0, and memAddr/memWriteData SHALL hold their last values.
REQ-012 The non-winning rdata and gnt SHALL be unchanged and 0, respectively, throughout.
REQ-013 At an IDLE edge with req0 and req1 both high, conflictCnt SHALL increment by 1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-014 ADDR_W SHALL be passed through unmodified; the arbiter SHALL NOT truncate or check address range.

Reset
REQ-015 When rst_n is low, the block SHALL asynchronously force state=IDLE, gnt0=gnt1=0, memRead=memWrite=0, memAddr=0, memWriteData=0, rdata0=rdata1=0, busy=0, conflictCnt=0, and lastGrant=1.
REQ-016 Reset asserted during ACCESS or RESP SHALL abort the access; no gnt SHALL be issued for it, and the requester SHALL re-request after reset.

Configuration
REQ-017 Macro DMEM_ARB_RR_EN SHALL select the tie-break rule.
- Defined: round-robin. On a tie, the port not equal to lastGrant wins, and lastGrant updates on every grant. After reset the CPU wins the first tie.
- Undefined: fixed priority. Port 0 (CPU) always wins a tie, and lastGrant is unused.
- A single requester SHALL always win immediately in both builds.

Verification
(Memory model holds mem[i]=i for i<1024.)
REQ-018 CPU read: req0=1, we0=0, addr0=5 -> memRead high for one cycle, then gnt0 high one cycle later with rdata0=5; gnt1=0 and rdata1=0.
REQ-019 DMA write then CPU read: DMA writes wdata1=99 to addr1=3, then CPU reads addr0=3 -> memWrite pulse with memAddr=3, memWriteData=99; rdata0=99; rdata1 unchanged.
REQ-020 Tie: req0 and req1 held high for 4 transactions.
- With DMEM_ARB_RR_EN: grant order 0,1,0,1.
- Without: order 0,0,0,0, with the DMA starved while CPU req stays high.
- conflictCnt=4 in both builds.
REQ-021 rst_n pulsed low during ACCESS of a read from addr 7 -> strobes drop immediately, no gnt issued, busy=0, conflictCnt=0; after re-request, rdata0=7.
REQ-022 Saturation: CNT_W=2 with 5 ties -> conflictCnt reads 3 and stays at 3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) data-memory arbiter: IDLE -> ACCESS -> RESP, fully registered outputs.
// Define DMEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] memReadData,
    output logic              busy,
    output logic [CNT_W-1:0]  conflictCnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_d;
    logic              win, win_d;
    logic              sel1;
    logic              gnt0_d, gnt1_d, memRead_d, memWrite_d, busy_d;
    logic [DATA_W-1:0] rdata0_d, rdata1_d, memWriteData_d;
    logic [ADDR_W-1:0] memAddr_d;
    logic [CNT_W-1:0]  conflictCnt_d;
`ifdef DMEM_ARB_RR_EN
    logic              lastGrant, lastGrant_d;
`endif

    // Port 1 wins when it requests alone, or on a tie when the tie-break favours it
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        sel1 = req1 & (~req0 | ~lastGrant);
`else
        sel1 = req1 & ~req0;
`endif
    end

    always_comb begin
        state_d        = state;
        win_d          = win;
        gnt0_d         = 1'b0;
        gnt1_d         = 1'b0;
        memRead_d      = 1'b0;
        memWrite_d     = 1'b0;
        busy_d         = busy;
        memAddr_d      = memAddr;
        memWriteData_d = memWriteData;
        rdata0_d       = rdata0;
        rdata1_d       = rdata1;
        conflictCnt_d  = conflictCnt;
`ifdef DMEM_ARB_RR_EN
        lastGrant_d    = lastGrant;
`endif
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    win_d          = sel1;
                    memAddr_d      = sel1 ? addr1 : addr0;
                    memWriteData_d = sel1 ? wdata1 : wdata0;
                    memWrite_d     = sel1 ? we1 : we0;
                    memRead_d      = ~(sel1 ? we1 : we0);
                    busy_d         = 1'b1;
                    state_d        = ACCESS;
                    if (req0 && req1 && conflictCnt != '1)
                        conflictCnt_d = conflictCnt + 1'b1;
`ifdef DMEM_ARB_RR_EN
                    lastGrant_d    = sel1;
`endif
                end
            end
            ACCESS: begin
                // memRead still holds the latched direction of the winner here
                if (memRead) begin
                    if (win) rdata1_d = memReadData;
                    else     rdata0_d = memReadData;
                end
                gnt0_d  = ~win;
                gnt1_d  = win;
                state_d = RESP;
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            win          <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            memRead      <= 1'b0;
            memWrite     <= 1'b0;
            busy         <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
            rdata0       <= '0;
            rdata1       <= '0;
            conflictCnt  <= '0;
`ifdef DMEM_ARB_RR_EN
            lastGrant    <= 1'b1;
`endif
        end else begin
            state        <= state_d;
            win          <= win_d;
            gnt0         <= gnt0_d;
            gnt1         <= gnt1_d;
            memRead      <= memRead_d;
            memWrite     <= memWrite_d;
            busy         <= busy_d;
            memAddr      <= memAddr_d;
            memWriteData <= memWriteData_d;
            rdata0       <= rdata0_d;
            rdata1       <= rdata1_d;
            conflictCnt  <= conflictCnt_d;
`ifdef DMEM_ARB_RR_EN
            lastGrant    <= lastGrant_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model, directed cases, random traffic.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq[2];
    logic        wq[2];
    logic [31:0] aq[2];
    logic [31:0] dq[2];

    logic        gnt0, gnt1, memRead, memWrite, busy;
    logic [31:0] rdata0, rdata1, memAddr, memWriteData, memReadData;
    logic [15:0] cnt;
    logic        gnt0_s, gnt1_s, memRead_s, memWrite_s, busy_s;
    logic [31:0] rdata0_s, rdata1_s, memAddr_s, memWriteData_s, memReadData_s;
    logic [1:0]  cnt_s;

    logic [31:0] mem [0:1023];
    logic [31:0] mmem[0:1023];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[0]), .we0(wq[0]), .addr0(aq[0]), .wdata0(dq[0]), .gnt0(gnt0), .rdata0(rdata0),
        .req1(rq[1]), .we1(wq[1]), .addr1(aq[1]), .wdata1(dq[1]), .gnt1(gnt1), .rdata1(rdata1),
        .memAddr(memAddr), .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite),
        .memReadData(memReadData), .busy(busy), .conflictCnt(cnt)
    );

    dmem_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .req0(rq[0]), .we0(wq[0]), .addr0(aq[0]), .wdata0(dq[0]), .gnt0(gnt0_s), .rdata0(rdata0_s),
        .req1(rq[1]), .we1(wq[1]), .addr1(aq[1]), .wdata1(dq[1]), .gnt1(gnt1_s), .rdata1(rdata1_s),
        .memAddr(memAddr_s), .memWriteData(memWriteData_s), .memRead(memRead_s), .memWrite(memWrite_s),
        .memReadData(memReadData_s), .busy(busy_s), .conflictCnt(cnt_s)
    );

    // Shared memory: both instances see identical traffic, so only the main DUT writes
    assign memReadData   = mem[memAddr[9:0]];
    assign memReadData_s = mem[memAddr_s[9:0]];
    initial for (int i = 0; i < 1024; i++) begin mem[i] = i; mmem[i] = i; end
    always @(posedge clk) if (memWrite) mem[memAddr[9:0]] <= memWriteData;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    // Reference model: one transaction at a time, grant at edge k, strobe cycle k, gnt cycle k+1
    logic        e_g0 = 0, e_g1 = 0, e_mr = 0, e_mw = 0, e_busy = 0;
    logic [31:0] e_addr = 0, e_wd = 0, e_rd0 = 0, e_rd1 = 0;
    int          e_cnt = 0, ties = 0, last = 1;
    longint      cyc = 0, tk = -100;
    int          tp = 0;
    logic        tw = 0;
    logic [31:0] ta = 0, td = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_g0 = 0; e_g1 = 0; e_mr = 0; e_mw = 0; e_busy = 0;
            e_addr = 0; e_wd = 0; e_rd0 = 0; e_rd1 = 0;
            ties = 0; e_cnt = 0; last = 1; tk = -100;
        end else begin
            cyc++;
            if (cyc == tk + 1) begin
                e_mr = 0; e_mw = 0;
                if (tw) mmem[ta[9:0]] = td;
                else if (tp == 1) e_rd1 = mmem[ta[9:0]];
                else e_rd0 = mmem[ta[9:0]];
                if (tp == 1) e_g1 = 1; else e_g0 = 1;
            end else if (cyc == tk + 2) begin
                e_g0 = 0; e_g1 = 0; e_busy = 0;
            end else if (cyc >= tk + 3 && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) begin
                    ties++;
`ifdef DMEM_ARB_RR_EN
                    tp = (last == 1) ? 0 : 1;
`else
                    tp = 0;
`endif
                end else tp = rq[1] ? 1 : 0;
                last = tp;
                tk = cyc;
                tw = wq[tp]; ta = aq[tp]; td = dq[tp];
                e_addr = ta; e_wd = td; e_mr = !tw; e_mw = tw; e_busy = 1;
            end
            e_cnt = ties;
        end
    end

    logic cmp_en = 0;
    logic gs[2];
    longint ncyc = 0, last_strobe = 0, last_gnt = 0;
    logic [31:0] w_addr = 0, w_data = 0;

    always @(posedge clk) ncyc++;

    always @(negedge clk) begin
        gs[0] = gnt0;
        gs[1] = gnt1;
        if (memRead | memWrite) last_strobe = ncyc;
        if (memWrite) begin w_addr = memAddr; w_data = memWriteData; end
        if (gnt0 | gnt1) last_gnt = ncyc;
        if (cmp_en) begin
            chk("gnt0", gnt0, e_g0);             chk("gnt1", gnt1, e_g1);
            chk("memRead", memRead, e_mr);       chk("memWrite", memWrite, e_mw);
            chk("memAddr", memAddr, e_addr);     chk("memWriteData", memWriteData, e_wd);
            chk("rdata0", rdata0, e_rd0);        chk("rdata1", rdata1, e_rd1);
            chk("busy", busy, e_busy);
            chk("conflictCnt", cnt, (e_cnt > 65535) ? 65535 : e_cnt);
            chk("s_gnt0", gnt0_s, e_g0);         chk("s_gnt1", gnt1_s, e_g1);
            chk("s_memRead", memRead_s, e_mr);   chk("s_memWrite", memWrite_s, e_mw);
            chk("s_memAddr", memAddr_s, e_addr); chk("s_rdata0", rdata0_s, e_rd0);
            chk("s_rdata1", rdata1_s, e_rd1);    chk("s_busy", busy_s, e_busy);
            chk("s_conflictCnt", cnt_s, (e_cnt > 3) ? 3 : e_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rq[0] = 0; rq[1] = 0;
        rst_n = 0;
        @(posedge clk);
        #3 rst_n = 1;
    endtask

    task automatic newreq(input int p);
        rq[p] = 1;
        wq[p] = 1'($urandom_range(1, 0));
        aq[p] = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(1023, 0));
        dq[p] = $urandom;
    endtask

    task automatic single(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic ok;
        ok = 0;
        rq[p] = 1; wq[p] = w; aq[p] = a; dq[p] = d;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (gs[p]) begin rq[p] = 0; ok = 1; end
        end
        rq[p] = 0;
        chk("single_done", ok, 1);
    endtask

    int exp_ord[4];
    int ord[$];
    int grants;
    logic done;

    initial begin
`ifdef DMEM_ARB_RR_EN
        exp_ord = '{0, 1, 0, 1};
`else
        exp_ord = '{0, 0, 0, 0};
`endif
        rq[0] = 0; rq[1] = 0; wq[0] = 0; wq[1] = 0;
        aq[0] = 0; aq[1] = 0; dq[0] = 0; dq[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_cnt", cnt, 0);
        #2 rst_n = 1;
        cmp_en = 1;

        // CPU read of address 5
        single(0, 0, 5, 0);
        chk("rd5_rdata0", rdata0, 5);
        chk("rd5_rdata1", rdata1, 0);
        chk("rd5_latency", last_gnt - last_strobe, 1);

        // DMA write 99 to 3, CPU read back
        single(1, 1, 3, 99);
        chk("wr_addr", w_addr, 3);
        chk("wr_data", w_data, 99);
        chk("wr_rdata1", rdata1, 0);
        chk("wr_rdata0", rdata0, 5);
        single(0, 0, 3, 0);
        chk("rb_rdata0", rdata0, 99);
        chk("rb_rdata1", rdata1, 0);

        // Both ports hold requests for four transactions
        do_reset();
        grants = 0;
        newreq(0); wq[0] = 0;
        newreq(1); wq[1] = 0;
        done = 0;
        for (int n = 0; n < 80 && !done; n++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && gs[p]) begin
                    rq[p] = 0;
                    if (ord.size() < 4) ord.push_back(p);
                    grants++;
                    if (grants < 4) begin newreq(p); wq[p] = 0; end
                end
            end
            if (!rq[0] && !rq[1]) done = 1;
        end
        chk("tie_done", done, 1);
        chk("tie_ngrants", ord.size(), 4);
        for (int i = 0; i < 4; i++) chk("tie_order", (i < ord.size()) ? ord[i] : -1, exp_ord[i]);
        repeat (3) tick();
        chk("tie_cnt", cnt, 4);
        chk("tie_cnt_sat", cnt_s, 3);

        // Reset during ACCESS of a read from address 7
        do_reset();
        tick();
        rq[0] = 1; wq[0] = 0; aq[0] = 7; dq[0] = 0;
        tick();
        chk("abort_memRead_pre", memRead, 1);
        #2 rst_n = 0;
        #1;
        chk("abort_memRead", memRead, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gnt0", gnt0, 0);
        chk("abort_cnt", cnt, 0);
        @(posedge clk);
        #3 rst_n = 1;
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            tick();
            if (gs[0]) begin rq[0] = 0; done = 1; end
        end
        chk("abort_regrant", done, 1);
        chk("abort_rdata0", rdata0, 7);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && gs[p]) begin
                    rq[p] = 0;
                    if ($urandom_range(1, 0) == 1) newreq(p);
                end else if (!rq[p] && $urandom_range(2, 0) == 0) begin
                    newreq(p);
                end
            end
        end
        for (int n = 0; n < 20; n++) begin
            tick();
            for (int p = 0; p < 2; p++) if (rq[p] && gs[p]) rq[p] = 0;
        end
        chk("rand_drained", rq[0] | rq[1], 0);
        chk("rand_cnt_sat", cnt_s, 3);

        cmp_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
